// File: rtl/vr_bcd_updown_cntr_if.sv
// vr_bcd_updown_cntr_if: control/data bundle for the BCD up/down counter (carries sat when VR_BCD_SAT_EN is defined)
interface vr_bcd_updown_cntr_if #(parameter int DIGITS = 4);
  logic clr;
  logic ld;
  logic enp;
  logic ent;
  logic up;
  logic [4*DIGITS-1:0] d;
  logic [4*DIGITS-1:0] q;
  logic rco;
  logic [DIGITS-1:0] dco;
`ifdef VR_BCD_SAT_EN
  logic sat;
  modport master(output clr, ld, enp, ent, up, d, input q, rco, dco, sat);
  modport slave(input clr, ld, enp, ent, up, d, output q, rco, dco, sat);
`else
  modport master(output clr, ld, enp, ent, up, d, input q, rco, dco);
  modport slave(input clr, ld, enp, ent, up, d, output q, rco, dco);
`endif
endinterface

// File: rtl/vr_bcd_updown_cntr.sv
// vr_bcd_updown_cntr: multi-decade BCD up/down counter with load, two-level enable and ripple carry (VR_BCD_SAT_EN selects saturation)
module vr_bcd_updown_cntr #(
  parameter int DIGITS = 4,
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic clr_n,
  vr_bcd_updown_cntr_if.slave bus
);
  logic [4*DIGITS-1:0] q;
  logic [4*DIGITS-1:0] nxt;
  logic [4*DIGITS-1:0] ld_v;
  logic [DIGITS-1:0] dco;
  logic [3:0] nib;
  logic [3:0] dn;
  logic [3:0] stp;
  logic carry;
  // per-digit step, ripple terminal chain and sanitised load value
  always_comb begin
    nxt = q;
    ld_v = '0;
    dco = '0;
    nib = '0;
    dn = '0;
    stp = '0;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nib = q[4*i+:4];
      dn = bus.d[4*i+:4];
      stp = bus.up ? (nib == 4'd9 ? 4'd0 : nib + 4'd1) : (nib == 4'd0 ? 4'd9 : nib - 4'd1);
      nxt[4*i+:4] = carry ? stp : nib;
      ld_v[4*i+:4] = dn > 4'd9 ? 4'd0 : dn;
      carry = carry & (bus.up ? nib == 4'd9 : nib == 4'd0);
      dco[i] = carry;
    end
  end
  assign bus.q = q;
  assign bus.dco = dco;
  assign bus.rco = bus.ent & dco[DIGITS-1];
`ifdef VR_BCD_SAT_EN
  logic sat;
  assign bus.sat = sat;
  // clear > load > count (held at terminal, flagging sat) > hold
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= RESET_VAL;
      sat <= 1'b0;
    end else if (bus.clr) begin
      q <= RESET_VAL;
      sat <= 1'b0;
    end else if (bus.ld) begin
      q <= ld_v;
      sat <= 1'b0;
    end else if (bus.enp && bus.ent) begin
      if (dco[DIGITS-1]) sat <= 1'b1;
      else q <= nxt;
    end
  end
`else
  // clear > load > count (wrapping at terminal) > hold
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q <= RESET_VAL;
    else if (bus.clr) q <= RESET_VAL;
    else if (bus.ld) q <= ld_v;
    else if (bus.enp && bus.ent) q <= nxt;
  end
`endif
endmodule

// File: tb/tb_vr_bcd_updown_cntr.sv
// tb_vr_bcd_updown_cntr: directed bench for the BCD up/down counter and a two-stage cascade
module tb_vr_bcd_updown_cntr;
  logic clk = 1'b0;
  logic clr_n;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;

  vr_bcd_updown_cntr_if #(.DIGITS(4)) i4 ();
  vr_bcd_updown_cntr_if #(.DIGITS(2)) il ();
  vr_bcd_updown_cntr_if #(.DIGITS(2)) ih ();

  vr_bcd_updown_cntr #(.DIGITS(4)) u4 (.clk(clk), .clr_n(clr_n), .bus(i4));
  vr_bcd_updown_cntr #(.DIGITS(2)) ulo (.clk(clk), .clr_n(clr_n), .bus(il));
  vr_bcd_updown_cntr #(.DIGITS(2)) uhi (.clk(clk), .clr_n(clr_n), .bus(ih));

  assign ih.clr = il.clr;
  assign ih.ld = il.ld;
  assign ih.enp = il.enp;
  assign ih.ent = il.rco;
  assign ih.up = il.up;
  assign ih.d = il.d;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n = 1'b0;
    {i4.clr, i4.ld, i4.enp, i4.ent} = '0;
    i4.up = 1'b1;
    i4.d = '0;
    {il.clr, il.ld, il.enp, il.ent} = '0;
    il.up = 1'b1;
    il.d = '0;
    #3;
    chk("reset_q", i4.q, 16'h0000);
    chk("reset_rco_up", 16'(i4.rco), 16'h0);
    #9;
    clr_n = 1'b1;
    // async clear mid-cycle
    i4.ld = 1'b1;
    i4.d = 16'h1234;
    tick;
    i4.ld = 1'b0;
    chk("load_1234", i4.q, 16'h1234);
    #2;
    clr_n = 1'b0;
    i4.ent = 1'b1;
    #1;
    chk("async_clr_q", i4.q, 16'h0000);
    chk("async_clr_rco_up", 16'(i4.rco), 16'h0);
    i4.up = 1'b0;
    #1;
    chk("rco_down_at_zero", 16'(i4.rco), 16'h1);
    clr_n = 1'b1;
    i4.up = 1'b1;
    // up count across decades
    i4.ld = 1'b1;
    i4.enp = 1'b1;
    i4.d = 16'h0998;
    tick;
    i4.ld = 1'b0;
    chk("load_0998", i4.q, 16'h0998);
    tick;
    chk("up_0999", i4.q, 16'h0999);
    chk("dco_0999", 16'(i4.dco), 16'h0007);
    chk("rco_0999", 16'(i4.rco), 16'h0);
    tick;
    chk("up_1000", i4.q, 16'h1000);
    chk("dco_1000", 16'(i4.dco), 16'h0000);
    tick;
    chk("up_1001", i4.q, 16'h1001);
    // wrap both directions
    i4.ld = 1'b1;
    i4.d = 16'h9999;
    tick;
    i4.ld = 1'b0;
    chk("load_9999", i4.q, 16'h9999);
    chk("rco_9999_up", 16'(i4.rco), 16'h1);
    chk("dco_9999_up", 16'(i4.dco), 16'h000f);
    i4.enp = 1'b0;
    #1;
    chk("rco_not_gated_by_enp", 16'(i4.rco), 16'h1);
    i4.enp = 1'b1;
    tick;
    chk("wrap_up_0000", i4.q, 16'h0000);
    chk("rco_0000_up", 16'(i4.rco), 16'h0);
    i4.up = 1'b0;
    #1;
    chk("rco_dir_change", 16'(i4.rco), 16'h1);
    tick;
    chk("wrap_down_9999", i4.q, 16'h9999);
    chk("rco_9999_down", 16'(i4.rco), 16'h0);
    i4.ld = 1'b1;
    i4.d = 16'h0100;
    tick;
    i4.ld = 1'b0;
    tick;
    chk("borrow_0099", i4.q, 16'h0099);
    // load sanitising and priorities
    i4.up = 1'b1;
    i4.ld = 1'b1;
    i4.d = 16'h3A5F;
    tick;
    chk("sanitised_load", i4.q, 16'h3050);
    i4.clr = 1'b1;
    i4.d = 16'h1111;
    tick;
    i4.clr = 1'b0;
    chk("clr_beats_ld", i4.q, 16'h0000);
    i4.d = 16'h0009;
    tick;
    i4.ld = 1'b0;
    chk("ld_beats_count", i4.q, 16'h0009);
    i4.ent = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("ent_low_hold", i4.q, 16'h0009);
      chk("ent_low_rco", 16'(i4.rco), 16'h0);
    end
    // two-stage cascade
    il.clr = 1'b1;
    tick;
    il.clr = 1'b0;
    chk("casc_clear", {ih.q, il.q}, 16'h0000);
    il.enp = 1'b1;
    il.ent = 1'b1;
    repeat (150) tick;
    chk("casc_lo", 16'(il.q), 16'h0050);
    chk("casc_hi", 16'(ih.q), 16'h0001);
`ifdef VR_BCD_SAT_EN
    i4.ld = 1'b1;
    i4.d = 16'h9999;
    i4.enp = 1'b1;
    i4.ent = 1'b1;
    i4.up = 1'b1;
    tick;
    i4.ld = 1'b0;
    chk("sat_load", 16'(i4.sat), 16'h0);
    tick;
    chk("sat_set", 16'(i4.sat), 16'h1);
    chk("sat_hold_q1", i4.q, 16'h9999);
    repeat (2) tick;
    chk("sat_hold_q3", i4.q, 16'h9999);
    chk("sat_rco", 16'(i4.rco), 16'h1);
    i4.ld = 1'b1;
    i4.d = 16'h0000;
    tick;
    i4.ld = 1'b0;
    chk("sat_cleared_by_ld", 16'(i4.sat), 16'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
